// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bus of the serial adder. Optional feature macro: SERIAL_ADDER_SUB_EN (adds sub).
// Handshake: start is a request taken on any rising edge where busy==0 (the operands are
// sampled on that same edge); done pulses for one cycle when sum/c_out hold the new result.
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out);
    modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out);
`else
    modport master (output start, a, b, c_in, input busy, done, sum, c_out);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif

endinterface

// File: rtl/serial_adder_one_adder.sv
// Single full-adder cell, reused by the serial controller for every bit position.
module one_adder (
    output logic s,
    output logic c_out,
    input  logic c_in,
    input  logic a,
    input  logic b
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, LSB first, carry registered.
// Optional feature macro: SERIAL_ADDER_SUB_EN (sub=1 computes a - b).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_if.slave     bus,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             c_out_q;
    logic [CW-1:0]    cnt;

    logic             cell_s;
    logic             cell_co;
    logic             accept;
    logic             last_bit;
    logic             busy_w;
    logic             done_w;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    one_adder u_cell (
        .s     (cell_s),
        .c_out (cell_co),
        .c_in  (carry),
        .a     (sa[0]),
        .b     (sb[0])
    );

    // New sum bit enters at the MSB so after WIDTH steps acc is LSB-aligned.
    assign acc_ext  = {cell_s, acc};
    assign accept   = bus.start && (state != S_RUN);
    assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.c_in;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.c_in;
`endif

    always_comb begin
        state_nxt = state;
        busy_w    = 1'b0;
        done_w    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy_w = 1'b1;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_w    = 1'b1;
                state_nxt = bus.start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sa      <= '0;
            sb      <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sa    <= bus.a;
                sb    <= b_load;
                acc   <= '0;
                carry <= carry_load;
                cnt   <= '0;
            end else if (state == S_RUN) begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                acc   <= acc_ext[WIDTH:1];
                carry <= cell_co;
                cnt   <= cnt + CW'(1);
                if (last_bit) begin
                    sum_q   <= acc_ext[WIDTH:1];
                    c_out_q <= cell_co;
                end
            end
        end
    end

    assign bus.busy  = busy_w;
    assign bus.done  = done_w;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit and a 3-bit instance checked
// against plain-arithmetic expected sums held in a queue.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] st8;
    logic [1:0] st3;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(3)) bus3 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus8.slave),
        .dbg_state (st8)
    );

    serial_adder_ctrl #(.WIDTH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3.slave),
        .dbg_state (st3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation starting from a quiet bus; hold=1 keeps start high and
    // scrambles the operands for the whole run.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sub, input bit hold, input string tag);
        int         k;
        int         busy_n;
        bit         seen;
        logic [8:0] e;
        @(negedge clk);
        bus8.a     = a;
        bus8.b     = b;
        bus8.c_in  = ci;
        bus8.start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = sub;
`endif
        if (sub) exp_q.push_back(9'(a) + 9'(~b) + 9'd1);
        else     exp_q.push_back(9'(a) + 9'(b) + 9'(ci));
        k      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (bus8.busy) busy_n++;
            if (bus8.done) seen = 1'b1;
            if (!hold || seen) begin
                bus8.start = 1'b0;
            end else begin
                bus8.a    = 8'($urandom);
                bus8.b    = 8'($urandom);
                bus8.c_in = 1'($urandom);
            end
        end
        e = exp_q.pop_front();
        chk({tag, "_latency"}, k, 9);
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_result"}, {bus8.c_out, bus8.sum}, e);
        @(negedge clk);
        chk({tag, "_done_once"}, {bus8.done, bus8.busy}, 2'b00);
    endtask

    // One 3-bit operation issued at the current negedge (back-to-back with the previous done).
    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic ci);
        int         k;
        bit         seen;
        logic [8:0] e;
        bus3.a     = a;
        bus3.b     = b;
        bus3.c_in  = ci;
        bus3.start = 1'b1;
        exp_q.push_back(9'(a) + 9'(b) + 9'(ci));
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus3.done) seen = 1'b1;
            bus3.start = 1'b0;
        end
        e = exp_q.pop_front();
        chk("w3_latency", k, 4);
        chk("w3_result", {bus3.c_out, bus3.sum}, e);
    endtask

    initial begin
        int nd;
        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.c_in  = 1'b0;
        bus3.start = 1'b0;
        bus3.a     = '0;
        bus3.b     = '0;
        bus3.c_in  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = 1'b0;
        bus3.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_sum", bus8.sum, 0);
        chk("rst_c_out", bus8.c_out, 0);
        chk("rst_state8", st8, 2'd0);
        chk("rst_state3", st3, 2'd0);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, "t1");
        chk("t1_sum_const", {bus8.c_out, bus8.sum}, 9'h096);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "t2a");
        chk("t2a_const", {bus8.c_out, bus8.sum}, 9'h100);
        op8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "t2b");
        chk("t2b_const", {bus8.c_out, bus8.sum}, 9'h001);

        op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1, "t3_hold");

        op8(8'h77, 8'h11, 1'b1, 1'b0, 1'b0, "t4_pre");
        @(negedge clk);
        bus8.a     = 8'h33;
        bus8.b     = 8'h44;
        bus8.c_in  = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_busy", bus8.busy, 0);
        chk("t4_done", bus8.done, 0);
        chk("t4_sum", bus8.sum, 0);
        chk("t4_c_out", bus8.c_out, 0);
        chk("t4_state", st8, 2'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done) nd++;
        end
        chk("t4_no_done", nd, 0);
        op8(8'hC3, 8'h5D, 1'b1, 1'b0, 1'b0, "t4_after");

        repeat (20) op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, "rand");

        @(negedge clk);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int c = 0; c < 2; c++)
                    op3(3'(i), 3'(j), 1'(c));
        @(negedge clk);
        chk("w3_idle_after", bus3.busy, 0);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, "t6a");
        chk("t6a_const", {bus8.c_out, bus8.sum}, 9'h10F);
        op8(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, "t6b");
        chk("t6b_const", {bus8.c_out, bus8.sum}, 9'h0FF);
        repeat (10) op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, "t6_rand");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
